// File: rtl/alu_muldiv.sv
// Multi-cycle RV32 execute unit: single-cycle base ALU ops plus an iterative
// radix-2 shift-add multiplier / restoring divider sharing one datapath.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_kill,
  input  logic [4:0]       i_alu_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_alu_data
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLT = 5'd2,  OP_SLTU = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_OR  = 5'd5,  OP_AND = 5'd6,  OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SRL = 5'd8,  OP_SRA = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15;
  localparam logic [4:0] OP_REM = 5'd16, OP_REMU = 5'd17;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state_q, state_d;

  logic                 acc, is_md, last;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     base_res;

  // captured operation and engine state
  logic [4:0]           op_q;
  logic [WIDTH-1:0]     a_q;
  logic                 b_zero_q, neg_q, neg_r_q;
  logic [WIDTH-1:0]     hi_q, lo_q, opnd_q;
  logic [SHAMT_W:0]     cnt_q;

  // setup values derived from the request
  logic                 sa, sb, is_mul_in;
  logic [WIDTH-1:0]     mag_a, mag_b;

  // next iteration and finalised result
  logic                 is_div_q;
  logic [WIDTH:0]       sum, r_sh, diff;
  logic [WIDTH-1:0]     hi_n, lo_n, fin;
  logic [2*WIDTH-1:0]   prod, prod_s;

  assign o_ready = (state_q != S_BUSY);
  assign o_valid = (state_q == S_DONE);
  assign acc     = i_valid && o_ready && !i_kill;
  assign is_md   = (i_alu_op >= OP_MUL) && (i_alu_op <= OP_REMU);
  assign shamt   = i_operand_b[SHAMT_W-1:0];
  assign last    = (cnt_q == (SHAMT_W+1)'(WIDTH-1));

  // single-cycle ALU result; illegal codes fall through to all ones
  always_comb begin
    base_res = '1;
    case (i_alu_op)
      OP_ADD:  base_res = i_operand_a + i_operand_b;
      OP_SUB:  base_res = i_operand_a - i_operand_b;
      OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(i_operand_a) < $signed(i_operand_b))};
      OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, (i_operand_a < i_operand_b)};
      OP_XOR:  base_res = i_operand_a ^ i_operand_b;
      OP_OR:   base_res = i_operand_a | i_operand_b;
      OP_AND:  base_res = i_operand_a & i_operand_b;
      OP_SLL:  base_res = i_operand_a << shamt;
      OP_SRL:  base_res = i_operand_a >> shamt;
      OP_SRA:  base_res = $unsigned($signed(i_operand_a) >>> shamt);
      default: base_res = '1;
    endcase
  end

  // engine runs on magnitudes; the sign fix-up is remembered for the end
  always_comb begin
    sa        = (i_alu_op == OP_MULH) || (i_alu_op == OP_MULHSU) ||
                (i_alu_op == OP_DIV)  || (i_alu_op == OP_REM);
    sb        = (i_alu_op == OP_MULH) || (i_alu_op == OP_DIV) || (i_alu_op == OP_REM);
    is_mul_in = (i_alu_op <= OP_MULHU);
    mag_a     = (sa && i_operand_a[WIDTH-1]) ? -i_operand_a : i_operand_a;
    mag_b     = (sb && i_operand_b[WIDTH-1]) ? -i_operand_b : i_operand_b;
  end

  // one multiply step (shift-add) or one restoring-divide step per cycle
  always_comb begin
    is_div_q = (op_q >= OP_DIV);
    sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    r_sh     = {hi_q, lo_q[WIDTH-1]};
    diff     = r_sh - {1'b0, opnd_q};
    if (is_div_q) begin
      hi_n = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // apply signs and divide-by-zero rules to the final iteration's values
  always_comb begin
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    fin    = '1;
    case (op_q)
      OP_MUL:                       fin = lo_n;
      OP_MULH, OP_MULHSU, OP_MULHU: fin = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fin = b_zero_q ? '1 : (neg_q ? -lo_n : lo_n);
      OP_REM, OP_REMU:              fin = b_zero_q ? a_q : (neg_r_q ? -hi_n : hi_n);
      default:                      fin = '1;
    endcase
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next state: kill wins over everything, DONE may chain straight into a new op
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (acc) state_d = is_md ? S_BUSY : S_DONE;
      S_BUSY: begin
        if (i_kill)    state_d = S_IDLE;
        else if (last) state_d = S_DONE;
      end
      S_DONE: begin
        if (i_kill)   state_d = S_IDLE;
        else if (acc) state_d = is_md ? S_BUSY : S_DONE;
        else          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // datapath: capture on accept, iterate while busy, hold result otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q       <= '0;
      a_q        <= '0;
      b_zero_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_r_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      o_alu_data <= '0;
    end else if (acc) begin
      op_q     <= i_alu_op;
      a_q      <= i_operand_a;
      b_zero_q <= (i_operand_b == '0);
      neg_q    <= (sa & i_operand_a[WIDTH-1]) ^ (sb & i_operand_b[WIDTH-1]);
      neg_r_q  <= sa & i_operand_a[WIDTH-1];
      hi_q     <= '0;
      lo_q     <= is_mul_in ? mag_b : mag_a;
      opnd_q   <= is_mul_in ? mag_a : mag_b;
      cnt_q    <= '0;
      if (!is_md) o_alu_data <= base_res;
    end else if (state_q == S_BUSY && !i_kill) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + (SHAMT_W+1)'(1);
      if (last) o_alu_data <= fin;
    end
  end

endmodule
